// File: rtl/adc_capture_buffer_pkg.sv
// adc_capture_buffer_pkg: state encoding, default widths and SPI opcodes for the capture buffer
package adc_capture_buffer_pkg;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 8;
  localparam int DECW_DEF = 16;
  localparam logic [7:0] CMD_ARM = 8'hA1;
  localparam logic [7:0] CMD_READ = 8'hA2;
  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE, READ} state_t;
endpackage

// File: rtl/adc_capture_ram.sv
// adc_capture_ram: simple dual-port sample store with a registered read port
module adc_capture_ram #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_q
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_q <= mem[rd_addr];
  end
endmodule

// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: decimated, triggered ADC capture into a circular RAM, streamed out oldest-first
module adc_capture_buffer
  import adc_capture_buffer_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int DECW = DECW_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [DW-1:0]   adc_data,
  input  logic            arm,
  input  logic            force_trig,
  input  logic [DW-1:0]   trig_level,
  input  logic            trig_rise,
  input  logic [AW-1:0]   pretrig,
  input  logic [DECW-1:0] decim,
  output logic            busy,
  output logic            done,
  input  logic            rd_req,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  output logic            rd_last
);
  state_t state, state_n;
  logic [DW-1:0] adc_q, s_prev, lvl, ram_q;
  logic rise, have_prev, v1, last1;
  logic [AW-1:0] pre, wp, tp, rp, cnt, idx;
  logic [AW:0] pc, post_len;
  logic [DECW-1:0] dec, dcnt, dec_eff;
  logic tick, we, hit, trig, acc;
  assign dec_eff = (dec == '0) ? DECW'(1) : dec;
  assign tick = dcnt == dec_eff - 1'b1;
  assign post_len = {1'b1, {AW{1'b0}}} - {1'b0, pre};
  // POST stops writing once the frame is full so the oldest pre-trigger sample survives
  assign we = tick && (state == PRE || state == WAIT_TRIG || (state == POST && pc != post_len));
  assign hit = we && have_prev && (rise ? (s_prev < lvl && lvl <= adc_q) : (s_prev >= lvl && lvl > adc_q));
  assign trig = state == WAIT_TRIG && (hit || force_trig);
  assign acc = rd_req && !arm && (state == DONE || (state == READ && !v1));
  assign busy = state == PRE || state == WAIT_TRIG || state == POST;
  assign done = state == DONE || state == READ;
  always_comb begin
    state_n = state;
    if (arm) state_n = PRE;
    else if (state == PRE && cnt == pre) state_n = WAIT_TRIG;
    else if (trig) state_n = POST;
    else if (state == POST && pc == post_len) state_n = DONE;
    else if (state == DONE && acc) state_n = READ;
    else if (state == READ && v1 && last1) state_n = DONE;
  end
  always_ff @(posedge clk) begin
    adc_q <= adc_data;
    if (!rstn) begin
      state <= IDLE;
      rd_data <= '0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
      v1 <= 1'b0;
      last1 <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      state <= state_n;
      v1 <= acc;
      last1 <= idx == '1;
      rd_valid <= v1 && !arm;
      rd_last <= v1 && !arm && last1;
      if (v1 && !arm) rd_data <= ram_q;
      if (arm) begin
        lvl <= trig_level;
        rise <= trig_rise;
        pre <= pretrig;
        dec <= decim;
        dcnt <= '0;
        cnt <= '0;
        wp <= '0;
        have_prev <= 1'b0;
      end else begin
        dcnt <= tick ? '0 : dcnt + 1'b1;
        if (we) begin
          wp <= wp + 1'b1;
          s_prev <= adc_q;
          have_prev <= 1'b1;
        end
        if (state == PRE && we) cnt <= cnt + 1'b1;
        if (trig) begin
          tp <= wp;
          pc <= {{AW{1'b0}}, we};
        end else if (state == POST && we) pc <= pc + 1'b1;
        if (state_n == DONE && state != DONE) begin
          rp <= tp - pre;
          idx <= '0;
        end else if (acc) begin
          rp <= rp + 1'b1;
          idx <= idx + 1'b1;
        end
      end
    end
  end
  adc_capture_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk(clk),
    .wr_en(we),
    .wr_addr(wp),
    .wr_data(adc_q),
    .rd_en(acc),
    .rd_addr(rp),
    .rd_q(ram_q)
  );
endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer: directed scenarios with a byte scoreboard for the capture buffer
module tb_adc_capture_buffer;
  localparam int DEPTH = 1024;
  logic clk = 1'b0, rstn = 1'b0, arm = 1'b0, force_trig = 1'b0, trig_rise = 1'b1, rd_req = 1'b0;
  logic [7:0] adc_data = 8'h00, trig_level = 8'h80;
  logic [9:0] pretrig = '0;
  logic [15:0] decim = 16'd1;
  logic busy, done, rd_valid, rd_last;
  logic [7:0] rd_data;
  logic ramp_on = 1'b0;
  int total = 0, bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got[DEPTH];

  adc_capture_buffer dut (
    .clk(clk), .rstn(rstn), .adc_data(adc_data), .arm(arm), .force_trig(force_trig),
    .trig_level(trig_level), .trig_rise(trig_rise), .pretrig(pretrig), .decim(decim),
    .busy(busy), .done(done), .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    if (ramp_on) adc_data = adc_data + 8'd1;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_arm(input logic [7:0] lvl, input logic rise, input logic [9:0] pre, input logic [15:0] dec);
    trig_level = lvl;
    trig_rise = rise;
    pretrig = pre;
    decim = dec;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse_force();
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic read_frame(input string tag, input int n);
    int derr = 0, lerr = 0, k;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      k = 0;
      while (rd_valid !== 1'b1 && k < 8) begin
        tick();
        k++;
      end
      if (k == 8) begin
        derr++;
        got[i] = 8'hxx;
      end else got[i] = rd_data;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (got[i] !== e) derr++;
      end
      if (rd_last !== (i == DEPTH - 1)) lerr++;
    end
    chk({tag, "_data_errs"}, derr, 0);
    chk({tag, "_last_errs"}, lerr, 0);
  endtask

  task automatic push_ramp(input logic [7:0] first, input logic [7:0] step, input int n);
    logic [7:0] v = first;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v);
      v = v + step;
    end
  endtask

  task automatic no_valid(input string tag, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      tick();
      seen = seen | rd_valid;
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    int n, derr;
    tick(3);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 0);
    chk("rst_rd_last", {31'd0, rd_last}, 0);
    chk("rst_rd_data", {24'd0, rd_data}, 0);
    rstn = 1'b1;
    ramp_on = 1'b1;
    tick(2);

    do_arm(8'h80, 1'b1, 10'd4, 16'd1);
    chk("t1_busy", {31'd0, busy}, 1);
    wait_done("t1_done", 3000);
    push_ramp(8'h7C, 8'd1, DEPTH);
    read_frame("t1", DEPTH);
    chk("t1_first_byte", {24'd0, got[0]}, 8'h7C);
    chk("t1_done_after_read", {31'd0, done}, 1);
    push_ramp(8'h7C, 8'd1, 1);
    read_frame("t1_rewind", 1);

    do_arm(8'h80, 1'b1, 10'd4, 16'd0);
    wait_done("t2_dec0_done", 3000);
    push_ramp(8'h7C, 8'd1, DEPTH);
    read_frame("t2_dec0", DEPTH);

    do_arm(8'h80, 1'b1, 10'd4, 16'd4);
    wait_done("t2_dec4_done", 8000);
    read_frame("t2_dec4", DEPTH);
    derr = 0;
    for (int i = 0; i < DEPTH - 1; i++) if (8'(got[i+1] - got[i]) !== 8'd4) derr++;
    chk("t2_dec4_step_errs", derr, 0);
    chk("t2_dec4_trig", {31'd0, got[4] >= 8'h80 && got[4] <= 8'h83 && got[3] < 8'h80}, 1);

    ramp_on = 1'b0;
    adc_data = 8'h10;
    tick(3);
    do_arm(8'h80, 1'b1, 10'd8, 16'd1);
    tick(30);
    chk("t3_no_self_trig", {31'd0, busy}, 1);
    pulse_force();
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk("t3_busy_fall_window", {31'd0, n >= DEPTH - 8 - 1 && n <= DEPTH - 8 + 3}, 1);
    chk("t3_done", {31'd0, done}, 1);
    push_ramp(8'h10, 8'd0, DEPTH);
    read_frame("t3", DEPTH);

    ramp_on = 1'b1;
    do_arm(8'h80, 1'b1, 10'h3FF, 16'd1);
    wait_done("t4_pmax_done", 5000);
    push_ramp(8'h81, 8'd1, DEPTH);
    read_frame("t4_pmax", DEPTH);
    chk("t4_pmax_trig_1023", {24'd0, got[1023]}, 8'h80);
    do_arm(8'h80, 1'b1, 10'd0, 16'd1);
    wait_done("t4_p0_done", 3000);
    push_ramp(8'h80, 8'd1, DEPTH);
    read_frame("t4_p0", DEPTH);
    chk("t4_p0_trig_0", {24'd0, got[0]}, 8'h80);

    ramp_on = 1'b0;
    adc_data = 8'h10;
    tick(3);
    do_arm(8'h80, 1'b1, 10'd8, 16'd1);
    tick(30);
    pulse_force();
    tick(50);
    adc_data = 8'h20;
    tick(3);
    do_arm(8'h80, 1'b1, 10'd8, 16'd1);
    chk("t5_post_rearm_busy", {31'd0, busy}, 1);
    chk("t5_post_rearm_done", {31'd0, done}, 0);
    tick(30);
    chk("t5_done_low_before_trig", {31'd0, done}, 0);
    pulse_force();
    wait_done("t5_done", 3000);
    push_ramp(8'h20, 8'd0, DEPTH);
    read_frame("t5", DEPTH);
    push_ramp(8'h20, 8'd0, 3);
    read_frame("t5_partial", 3);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("t5_read_rearm_valid", {31'd0, rd_valid}, 0);
    no_valid("t5_read_rearm_no_valid", 6);
    chk("t5_read_rearm_done", {31'd0, done}, 0);
    chk("t5_read_rearm_busy", {31'd0, busy}, 1);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    no_valid("t5_rdreq_while_busy", 5);
    pulse_force();
    wait_done("t5_second_done", 3000);
    push_ramp(8'h20, 8'd0, 5);
    read_frame("t6_pre", 5);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_done", {31'd0, done}, 0);
    chk("t6_rd_valid", {31'd0, rd_valid}, 0);
    chk("t6_rd_last", {31'd0, rd_last}, 0);
    chk("t6_rd_data", {24'd0, rd_data}, 0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    no_valid("t6_rdreq_after_reset", 6);
    chk("t6_done_stays_low", {31'd0, done}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
